c16_wport: RTL and testbench

Parametrised peripheral write port for the c16 system. It buffers write commands from the core in a small FIFO and replays them onto the shared peripheral write bus (`w_param`/`w_index`/`w_val`) with a one-hot write enable per target (sound, video, further targets by parameter). It adds per-target flow control and burst-fill writes: one command writes the same value to `count` consecutive indices. It sits between the c16 core and the sound/video units and replaces direct per-cycle strobing of `snd_wen`/`vid_wen`.

---
 rtl/c16_wport_if.sv | 36 +++
 rtl/c16_wport.sv | 145 ++++++++++++++
 tb/tb_c16_wport.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c16_wport_if.sv
// c16_wport_if: write-command channel from the c16 core into c16_wport.
//   req_valid  command present (core -> port)
//   req_ready  port can accept a command (port -> core)
//   req_tgt    target number (0 = sound, 1 = video, ...)
//   req_param  parameter select
//   req_index  first index of the burst
//   req_val    value written on every beat
//   req_count  number of beats, 0 means 1
// master = core side, slave = c16_wport side.
interface c16_wport_if #(
    parameter int NTGT    = 2,
    parameter int PARAM_W = 2,
    parameter int INDEX_W = 11,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 4
);
    localparam int TGT_W = (NTGT > 1) ? $clog2(NTGT) : 1;

    logic               req_valid;
    logic               req_ready;
    logic [TGT_W-1:0]   req_tgt;
    logic [PARAM_W-1:0] req_param;
    logic [INDEX_W-1:0] req_index;
    logic [DATA_W-1:0]  req_val;
    logic [CNT_W-1:0]   req_count;

    modport master (
        output req_valid, req_tgt, req_param, req_index, req_val, req_count,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_tgt, req_param, req_index, req_val, req_count,
        output req_ready
    );
endinterface

// File: rtl/c16_wport.sv
// c16_wport: buffered, flow-controlled peripheral write port.
// Write commands are queued in a DEPTH-entry FIFO, then replayed as bursts
// onto the shared write bus: one beat per cycle while the addressed target
// is ready, same value to `count` consecutive (wrapping) indices.
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   req                command channel (slave modport of c16_wport_if)
//   tgt_ready[NTGT]    target i can take a beat this cycle
//   wen[NTGT]          registered one-hot write enable
//   w_param/w_index/w_val  registered write bus, held between beats
//   busy               engine active or FIFO non-empty
//   level              FIFO occupancy, 0..DEPTH
module c16_wport #(
    parameter int NTGT    = 2,
    parameter int PARAM_W = 2,
    parameter int INDEX_W = 11,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 4,
    localparam int TGT_W  = (NTGT > 1) ? $clog2(NTGT) : 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int LVL_W  = AW + 1
) (
    input  logic               clk,
    input  logic               resetn,
    c16_wport_if.slave         req,
    input  logic [NTGT-1:0]    tgt_ready,
    output logic [NTGT-1:0]    wen,
    output logic [PARAM_W-1:0] w_param,
    output logic [INDEX_W-1:0] w_index,
    output logic [DATA_W-1:0]  w_val,
    output logic               busy,
    output logic [LVL_W-1:0]   level
);

    typedef struct packed {
        logic [TGT_W-1:0]   tgt;
        logic [PARAM_W-1:0] param;
        logic [INDEX_W-1:0] index;
        logic [DATA_W-1:0]  val;
        logic [CNT_W-1:0]   count;
    } cmd_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    // ---------------- command FIFO ----------------
    cmd_t           mem [DEPTH];
    cmd_t           head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           full, empty, push, pop;
    state_t         state;

    assign full          = (level == LVL_W'(DEPTH));
    assign empty         = (level == '0);
    // ready depends only on registered occupancy: a pop in the same cycle
    // does not open a slot early
    assign req.req_ready = !full;
    assign push          = req.req_valid && !full;
    assign pop           = (state == IDLE) && !empty;
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{tgt: req.req_tgt, param: req.req_param,
                             index: req.req_index, val: req.req_val,
                             count: req.req_count};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ---------------- burst engine ----------------
    logic [TGT_W-1:0]   b_tgt;
    logic [PARAM_W-1:0] b_param;
    logic [INDEX_W-1:0] b_index;
    logic [DATA_W-1:0]  b_val;
    logic [CNT_W-1:0]   b_rem;
    logic [NTGT-1:0]    tgt_oh;
    logic               tgt_ok, rdy_hit, beat;

    for (genvar i = 0; i < NTGT; i++) begin : g_oh
        assign tgt_oh[i] = (b_tgt == TGT_W'(i));
    end

    // an out-of-range target decodes to all-zero: beats drain unconditionally
    assign tgt_ok  = |tgt_oh;
    assign rdy_hit = |(tgt_oh & tgt_ready);
    assign beat    = (state == ISSUE) && (rdy_hit || !tgt_ok);
    assign busy    = (state != IDLE) || !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            b_tgt   <= '0;
            b_param <= '0;
            b_index <= '0;
            b_val   <= '0;
            b_rem   <= '0;
            wen     <= '0;
            w_param <= '0;
            w_index <= '0;
            w_val   <= '0;
        end else begin
            wen <= '0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        b_tgt   <= head.tgt;
                        b_param <= head.param;
                        b_index <= head.index;
                        b_val   <= head.val;
                        b_rem   <= (head.count == '0) ? CNT_W'(1) : head.count;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (beat) begin
                        wen     <= tgt_oh;
                        w_param <= b_param;
                        w_index <= b_index;
                        w_val   <= b_val;
                        b_index <= b_index + 1'b1;
                        b_rem   <= b_rem - 1'b1;
                        if (b_rem == CNT_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c16_wport.sv
module tb_c16_wport;
    // NTGT=3 gives a 2-bit target field so tgt=3 is a representable invalid target
    localparam int NTGT = 3, PARAM_W = 2, INDEX_W = 11, DATA_W = 16;
    localparam int DEPTH = 4, CNT_W = 4, TGT_W = 2, LVL_W = 3;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NTGT-1:0]    tgt_ready, wen, rdy_at_edge;
    logic [PARAM_W-1:0] w_param;
    logic [INDEX_W-1:0] w_index;
    logic [DATA_W-1:0]  w_val;
    logic               busy;
    logic [LVL_W-1:0]   level;

    c16_wport_if #(.NTGT(NTGT), .PARAM_W(PARAM_W), .INDEX_W(INDEX_W),
                   .DATA_W(DATA_W), .CNT_W(CNT_W)) rif();

    c16_wport #(.NTGT(NTGT), .PARAM_W(PARAM_W), .INDEX_W(INDEX_W),
                .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .req(rif), .tgt_ready(tgt_ready),
        .wen(wen), .w_param(w_param), .w_index(w_index), .w_val(w_val),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;

    typedef struct packed {
        logic [NTGT-1:0]    wen;
        logic [PARAM_W-1:0] p;
        logic [INDEX_W-1:0] i;
        logic [DATA_W-1:0]  v;
    } beat_t;

    beat_t exq[$];
    beat_t mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: an accepted command expands into max(count,1) beats at
    // consecutive indices modulo 2^INDEX_W; invalid targets produce none.
    task automatic model_add(input int t, input int p, input int ix, input int v, input int c);
        int n;
        beat_t b;
        n = (c == 0) ? 1 : c;
        if (t < NTGT) begin
            for (int k = 0; k < n; k++) begin
                b.wen = NTGT'(1 << t);
                b.p   = PARAM_W'(p);
                b.i   = INDEX_W'((ix + k) % (1 << INDEX_W));
                b.v   = DATA_W'(v);
                exq.push_back(b);
            end
        end
    endtask

    always @(posedge clk) rdy_at_edge <= tgt_ready;

    // every beat seen on the bus must be the next expected one, in order,
    // and only to a target that was ready at the issuing edge
    always @(negedge clk) begin
        if (resetn === 1'b1 && wen !== '0) begin
            if (exq.size() == 0) begin
                chk("unexpected_beat", 64'(wen), 64'(0));
            end else begin
                mon_e = exq.pop_front();
                chk("beat", 64'({wen, w_param, w_index, w_val}), 64'(mon_e));
            end
            chk("flow", 64'(wen & ~rdy_at_edge), 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) tgt_ready = NTGT'($urandom);
    endtask

    // returns one ns after the edge that accepted the command
    task automatic push(input int t, input int p, input int ix, input int v, input int c);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        rif.req_valid = 1'b1;
        rif.req_tgt   = TGT_W'(t);
        rif.req_param = PARAM_W'(p);
        rif.req_index = INDEX_W'(ix);
        rif.req_val   = DATA_W'(v);
        rif.req_count = CNT_W'(c);
        while (!acc && n < 200) begin
            acc = rif.req_ready;
            step();
            n++;
        end
        rif.req_valid = 1'b0;
        if (acc) model_add(t, p, ix, v, c);
        else chk("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || exq.size() != 0) && n < lim) begin
            step();
            n++;
        end
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_queue", 64'(exq.size()), 64'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wen"},   64'(wen), 64'(0));
        chk({tag, "_param"}, 64'(w_param), 64'(0));
        chk({tag, "_index"}, 64'(w_index), 64'(0));
        chk({tag, "_val"},   64'(w_val), 64'(0));
        chk({tag, "_level"}, 64'(level), 64'(0));
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_ready"}, 64'(rif.req_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        tgt_ready     = '0;
        rif.req_valid = 1'b0;
        rif.req_tgt   = '0;
        rif.req_param = '0;
        rif.req_index = '0;
        rif.req_val   = '0;
        rif.req_count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        resetn = 1'b1;
        step();

        // single write: beat two edges after the push, exactly one cycle
        tgt_ready = '1;
        push(1, 2, 'h010, 'h1234, 1);
        chk("t1_wen_T0", 64'(wen), 64'(0));
        step();
        chk("t1_wen_T1", 64'(wen), 64'(0));
        step();
        chk("t1_wen", 64'(wen), 64'(3'b010));
        chk("t1_param", 64'(w_param), 64'(2));
        chk("t1_index", 64'(w_index), 64'('h010));
        chk("t1_val", 64'(w_val), 64'('h1234));
        step();
        chk("t1_wen_off", 64'(wen), 64'(0));
        chk("t1_busy", 64'(busy), 64'(0));

        // burst with index wrap
        push(0, 1, 'h7FE, 'hBEEF, 4);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_wen", 64'(wen), 64'(3'b001));
            chk("t2_index", 64'(w_index), 64'((('h7FE + k) % 2048)));
            chk("t2_val", 64'(w_val), 64'('hBEEF));
        end
        step();
        chk("t2_wen_off", 64'(wen), 64'(0));

        // count=0 is a single beat
        push(0, 3, 'h100, 'h55AA, 0);
        step();
        step();
        chk("t2c0_wen", 64'(wen), 64'(3'b001));
        chk("t2c0_index", 64'(w_index), 64'('h100));
        step();
        chk("t2c0_wen_off", 64'(wen), 64'(0));
        chk("t2c0_busy", 64'(busy), 64'(0));

        // stall for 3 cycles after beat 2
        push(0, 0, 'h7FE, 'hBEEF, 4);
        step();
        step();
        chk("t3_b1", 64'(w_index), 64'('h7FE));
        step();
        chk("t3_b2", 64'(w_index), 64'('h7FF));
        tgt_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_stall_wen", 64'(wen), 64'(0));
        end
        tgt_ready[0] = 1'b1;
        step();
        chk("t3_b3_wen", 64'(wen), 64'(3'b001));
        chk("t3_b3_index", 64'(w_index), 64'('h000));
        step();
        chk("t3_b4_wen", 64'(wen), 64'(3'b001));
        chk("t3_b4_index", 64'(w_index), 64'('h001));
        step();
        chk("t3_wen_off", 64'(wen), 64'(0));

        // backpressure: engine holds one command, FIFO fills with four more
        tgt_ready = '0;
        for (int j = 0; j < 5; j++) push(0, 0, 'h200 + j * 16, j, 1);
        chk("t4_level", 64'(level), 64'(4));
        chk("t4_ready", 64'(rif.req_ready), 64'(0));
        rif.req_valid = 1'b1;
        rif.req_tgt   = '0;
        rif.req_index = INDEX_W'('h250);
        rif.req_val   = DATA_W'(5);
        rif.req_count = CNT_W'(1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_ready", 64'(rif.req_ready), 64'(0));
            chk("t4_hold_level", 64'(level), 64'(4));
            chk("t4_hold_wen", 64'(wen), 64'(0));
        end
        tgt_ready = '1;
        push(0, 0, 'h250, 5, 1);
        wait_idle(200);

        // invalid target drains without strobes even with tgt_ready low
        tgt_ready = '0;
        push(3, 1, 'h050, 'hDEAD, 2);
        push(0, 2, 'h060, 'hCAFE, 1);
        chk("t5_wen_T1", 64'(wen), 64'(0));
        step();
        chk("t5_wen_T2", 64'(wen), 64'(0));
        step();
        chk("t5_wen_T3", 64'(wen), 64'(0));
        step();
        chk("t5_level", 64'(level), 64'(0));
        chk("t5_busy", 64'(busy), 64'(1));
        chk("t5_wen_T4", 64'(wen), 64'(0));
        tgt_ready = '1;
        step();
        chk("t5_wen", 64'(wen), 64'(3'b001));
        chk("t5_index", 64'(w_index), 64'('h060));
        chk("t5_val", 64'(w_val), 64'('hCAFE));
        step();
        chk("t5_busy_end", 64'(busy), 64'(0));

        // asynchronous reset during beat 2 of an 8-beat burst, 2 queued
        push(1, 0, 'h300, 'h1111, 8);
        push(1, 1, 'h400, 'h2222, 1);
        push(2, 2, 'h500, 'h3333, 3);
        step();
        chk("t6_b2_wen", 64'(wen), 64'(3'b010));
        chk("t6_b2_index", 64'(w_index), 64'('h301));
        #2;
        resetn = 1'b0;
        #1;
        exq.delete();
        chk_reset_vals("t6_async");
        step();
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t6_post_wen", 64'(wen), 64'(0));
        end
        chk("t6_post_level", 64'(level), 64'(0));
        chk("t6_post_busy", 64'(busy), 64'(0));

        // randomized commands and target readiness against the scoreboard
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            push($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2047),
                 $urandom_range(0, 65535), $urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle(3000);
        rnd_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
